// File: rtl/probador_sumador_restador.sv
// Exhaustive 512-vector sweep tester for a 4-bit adder/subtractor (op, two nibbles in, 5-bit result back).
// Optional build macro PROBADOR_ERROR_COUNT_EN: adds err_count and always runs the full sweep.
module probador_sumador_restador #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       op,
  output logic       D1,
  output logic       C1,
  output logic       B1,
  output logic       A1,
  output logic       D2,
  output logic       C2,
  output logic       B2,
  output logic       A2,
  input  logic       e,
  input  logic       d,
  input  logic       c,
  input  logic       b,
  input  logic       a,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [8:0] err_index,
  output logic [4:0] err_exp,
  output logic [4:0] err_got
`ifdef PROBADOR_ERROR_COUNT_EN
  ,
  output logic [9:0] err_count
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(SETTLE - 1);

  // Reference result for one vector: bit 8 selects subtract, result wraps modulo 32.
  function automatic logic [4:0] expectedResult(input logic [8:0] idx);
    logic [4:0] op1;
    logic [4:0] op2;
    op1 = {1'b0, idx[7:4]};
    op2 = {1'b0, idx[3:0]};
    if (idx[8] == 1'b1) begin
      expectedResult = op1 - op2;
    end else begin
      expectedResult = op1 + op2;
    end
  endfunction

  state_t     state_r,    state_s;
  logic [8:0] vecIndex_r, vecIndex_s;
  logic [8:0] opVec_r,    opVec_s;
  logic [3:0] waitCnt_r,  waitCnt_s;
  logic       busy_r,     busy_s;
  logic       done_r,     done_s;
  logic       pass_r,     pass_s;
  logic       errSeen_r,  errSeen_s;
  logic [8:0] errIndex_r, errIndex_s;
  logic [4:0] errExp_r,   errExp_s;
  logic [4:0] errGot_r,   errGot_s;
`ifdef PROBADOR_ERROR_COUNT_EN
  logic [9:0] errCount_r, errCount_s;
`endif

  logic [4:0] got_s;
  logic [4:0] exp_s;
  logic       match_s;

  assign got_s   = {e, d, c, b, a};
  assign exp_s   = expectedResult(vecIndex_r);
  // An X/Z on the result makes the equality unknown, which the CHECK branch treats as a mismatch.
  assign match_s = (got_s == exp_s);

  // Next-state and next-output computation for the sweep sequencer.
  always_comb begin
    state_s    = state_r;
    vecIndex_s = vecIndex_r;
    opVec_s    = opVec_r;
    waitCnt_s  = waitCnt_r;
    busy_s     = busy_r;
    done_s     = done_r;
    pass_s     = pass_r;
    errSeen_s  = errSeen_r;
    errIndex_s = errIndex_r;
    errExp_s   = errExp_r;
    errGot_s   = errGot_r;
`ifdef PROBADOR_ERROR_COUNT_EN
    errCount_s = errCount_r;
`endif
    case (state_r)
      IDLE, DONE: begin
        if (start == 1'b1) begin
          state_s    = DRIVE;
          vecIndex_s = 9'd0;
          busy_s     = 1'b1;
          done_s     = 1'b0;
          pass_s     = 1'b0;
          errSeen_s  = 1'b0;
          errIndex_s = 9'd0;
          errExp_s   = 5'd0;
          errGot_s   = 5'd0;
`ifdef PROBADOR_ERROR_COUNT_EN
          errCount_s = 10'd0;
`endif
        end else begin
          state_s = state_r;
        end
      end
      DRIVE: begin
        opVec_s   = vecIndex_r;
        waitCnt_s = 4'd0;
        state_s   = WAIT;
      end
      WAIT: begin
        if (waitCnt_r == WAIT_LAST) begin
          state_s = CHECK;
        end else begin
          waitCnt_s = waitCnt_r + 4'd1;
        end
      end
      CHECK: begin
        if (match_s == 1'b1) begin
          if (vecIndex_r == 9'd511) begin
            state_s = DONE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
            pass_s  = ~errSeen_r;
          end else begin
            vecIndex_s = vecIndex_r + 9'd1;
            state_s    = DRIVE;
          end
        end else begin
          if (errSeen_r == 1'b0) begin
            errIndex_s = vecIndex_r;
            errExp_s   = exp_s;
            errGot_s   = got_s;
          end else begin
            errIndex_s = errIndex_r;
          end
          errSeen_s = 1'b1;
`ifdef PROBADOR_ERROR_COUNT_EN
          errCount_s = errCount_r + 10'd1;
          if (vecIndex_r == 9'd511) begin
            state_s = DONE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
            pass_s  = 1'b0;
          end else begin
            vecIndex_s = vecIndex_r + 9'd1;
            state_s    = DRIVE;
          end
`else
          state_s = DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          pass_s  = 1'b0;
`endif
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        pass_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; rst returns everything to idle zero at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      vecIndex_r <= 9'd0;
      opVec_r    <= 9'd0;
      waitCnt_r  <= 4'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
      errSeen_r  <= 1'b0;
      errIndex_r <= 9'd0;
      errExp_r   <= 5'd0;
      errGot_r   <= 5'd0;
`ifdef PROBADOR_ERROR_COUNT_EN
      errCount_r <= 10'd0;
`endif
    end else begin
      state_r    <= state_s;
      vecIndex_r <= vecIndex_s;
      opVec_r    <= opVec_s;
      waitCnt_r  <= waitCnt_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      pass_r     <= pass_s;
      errSeen_r  <= errSeen_s;
      errIndex_r <= errIndex_s;
      errExp_r   <= errExp_s;
      errGot_r   <= errGot_s;
`ifdef PROBADOR_ERROR_COUNT_EN
      errCount_r <= errCount_s;
`endif
    end
  end

  assign {op, D1, C1, B1, A1, D2, C2, B2, A2} = opVec_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign err_index = errIndex_r;
  assign err_exp   = errExp_r;
  assign err_got   = errGot_r;
`ifdef PROBADOR_ERROR_COUNT_EN
  assign err_count = errCount_r;
`endif

endmodule

// File: doc/probador_sumador_restador.md
PROBADOR_SUMADOR_RESTADOR -- requirements
Module: probador_sumador_restador

Interface
REQ-001 Parameter SETTLE, default 2, number of wait cycles between applying a vector and sampling the result; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle request to run the full 512-vector sweep; sampled only in IDLE.
REQ-005 op  output  1  operation driven to the adder/subtractor (0 = add, 1 = subtract).
REQ-006 D1, C1, B1, A1  output  1 each  operand 1, D1 = MSB.
REQ-007 D2, C2, B2, A2  output  1 each  operand 2, D2 = MSB.
REQ-008 e, d, c, b, a  input  1 each  5-bit result returned by the adder/subtractor, e = MSB.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  high once a sweep has ended; held until the next accepted start.
REQ-011 pass  output  1  high with done when no mismatch occurred.
REQ-012 err_index  output  9  vector index of the first mismatch.
REQ-013 err_exp, err_got  output  5 each  expected and received {e,d,c,b,a} at the first mismatch.

Function
REQ-014 A 9-bit vector index SHALL map as bit 8 = op, bits 7:4 = {D1,C1,B1,A1}, bits 3:0 = {D2,C2,B2,A2}; the sweep runs indices 0..511 in ascending order.
REQ-015 Expected result for op=0 SHALL be the 5-bit sum op1+op2 (0..30).
REQ-016 Expected result for op=1 SHALL be (op1-op2) mod 32, i.e. a 5-bit two's-complement difference (e.g. 3-5 -> 5'h1E).
REQ-017 FSM states SHALL be IDLE, DRIVE, WAIT, CHECK, DONE.
REQ-018 IDLE -> DRIVE on start=1; index cleared to 0; done, pass, err_* cleared; busy set.
REQ-019 DRIVE (1 cycle) SHALL register the operand and op outputs from the index; the next state is WAIT.
REQ-020 WAIT SHALL last exactly SETTLE cycles, then go to CHECK.
REQ-021 CHECK (1 cycle) SHALL compare {e,d,c,b,a} with the expected value; each vector therefore takes SETTLE+2 cycles.
REQ-022 On a CHECK match with index < 511: increment index and go to DRIVE; with index = 511: go to DONE with pass=1.
REQ-023 On the first mismatch: capture err_index, err_exp and err_got; these SHALL NOT be overwritten by later mismatches.
REQ-024 DONE SHALL hold done=1 and busy=0; a start in DONE SHALL begin a new sweep exactly as from IDLE.
REQ-025 start while busy=1 SHALL be ignored.
REQ-026 Any X/Z on {e,d,c,b,a} at CHECK SHALL count as a mismatch.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, index=0, and all outputs to 0, including mid-sweep; no sweep resumes after reset is released.

Configuration
REQ-028 Macro PROBADOR_ERROR_COUNT_EN defined: add output err_count (10 bits, reset 0), incremented on every mismatch; the sweep always completes all 512 vectors; pass = (err_count == 0) at DONE.
REQ-029 Macro not defined: no err_count port; the first mismatch goes directly to DONE with pass=0.

Verification
REQ-030 Correct DUT, SETTLE=2, single start pulse -> done=1, pass=1 exactly 512*4 cycles after DRIVE first entered; err_* all 0.
REQ-031 DUT with a stuck at 0, macro undefined -> done=1, pass=0, err_index=1, err_exp=5'h01, err_got=5'h00; op/operand outputs frozen at index 1.
REQ-032 Correct DUT except index 309 (op=1, op1=3, op2=5) returns 5'h02 -> err_index=309, err_exp=5'h1E, err_got=5'h02.
REQ-033 rst asserted asynchronously at index 100 mid-WAIT -> all outputs 0 immediately; busy stays 0 after release until a new start is given.
REQ-034 start pulsed again during a sweep -> no restart; the index sequence is unchanged.
REQ-035 Macro defined, a stuck at 0 -> all 512 vectors run; done=1, pass=0, err_count=256, err_index=1.
